// File: rtl/data_restore_pkg.sv
// Shared constants, byte type and hard-demap helpers for the OFDM data-restore path.
package data_restore_pkg;

   localparam logic [1:0] MOD_BPSK  = 2'd0;
   localparam logic [1:0] MOD_QPSK  = 2'd1;
   localparam logic [1:0] MOD_16QAM = 2'd2;
   localparam logic [1:0] MOD_RSV   = 2'd3;

   localparam logic [7:0] SYM_LONG1 = 8'd1;
   localparam logic [7:0] SYM_LONG2 = 8'd2;
   localparam logic [7:0] SYM_DATA0 = 8'd3;

   // 802.11a: nulls at 0, 27..37; pilots at 7, 21, 43, 57.
   localparam logic [63:0] DATA_MASK_80211 = 64'hFDFF_F7C0_07DF_FF7E;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
   } axis_byte_t;

   // Demapped bits left-aligned in stream order; unused low bits are 0.
   function automatic logic [3:0] demap(input logic [1:0] mode, input logic sign_r,
                                        input logic sign_i, input logic small_r,
                                        input logic small_i);
      case (mode)
         MOD_BPSK:  return {~sign_r, 3'b000};
         MOD_QPSK:  return {~sign_r, ~sign_i, 2'b00};
         MOD_16QAM: return {~sign_r, small_r, ~sign_i, small_i};
         default:   return 4'b0000;
      endcase
   endfunction

   function automatic logic [2:0] bits_per_sym(input logic [1:0] mode);
      case (mode)
         MOD_BPSK:  return 3'd1;
         MOD_QPSK:  return 3'd2;
         MOD_16QAM: return 3'd4;
         default:   return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through byte FIFO with last/user sideband and occupancy output.
module axis_sync_fifo import data_restore_pkg::*; #(
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  axis_byte_t               wr_data,
   output logic                     wr_drop,
   output logic                     out_valid,
   input  logic                     out_ready,
   output axis_byte_t               out_data,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   axis_byte_t      mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic            full, rd, wr_ok;

   assign full      = (level == LW'(DEPTH));
   assign out_valid = (level != '0);
   assign rd        = out_valid && out_ready;
   // A read at full frees its slot in the same cycle.
   assign wr_ok     = wr_en && (!full || rd);
   assign wr_drop   = wr_en && !wr_ok;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd)    rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/data_restore_multi.sv
// OFDM receive data restore: carrier filtering, BPSK/QPSK/16QAM hard demap, byte packing, AXIS out.
module data_restore_multi import data_restore_pkg::*; #(
   parameter int unsigned      IQ_W       = 8,
   parameter int unsigned      NFFT       = 64,
   parameter logic [NFFT-1:0]  DATA_MASK  = DATA_MASK_80211,
   parameter int unsigned      QAM16_THR  = 32,
   parameter int unsigned      FIFO_DEPTH = 64
) (
   input  logic                          CLK,
   input  logic                          Rst_n,
   input  logic                          io_inputDataEn,
   input  logic [IQ_W-1:0]               io_inputDataR,
   input  logic [IQ_W-1:0]               io_inputDataI,
   input  logic [7:0]                    io_inputSymbol,
   input  logic [1:0]                    io_modSel,
   input  logic [7:0]                    io_numSymbols,
   output logic                          io_axisOut_valid,
   input  logic                          io_axisOut_ready,
   output logic [7:0]                    io_axisOut_payload_data,
   output logic                          io_axisOut_payload_last,
   output logic                          io_axisOut_payload_user,
   output logic [$clog2(FIFO_DEPTH):0]   io_fifoLevel,
   output logic                          io_overflow,
   output logic                          io_symErr
);

   function automatic int unsigned find_last(input logic [NFFT-1:0] m);
      int unsigned pos = 0;
      for (int k = 0; k < NFFT; k++) if (m[k]) pos = k;
      return pos;
   endfunction

   function automatic logic [IQ_W-1:0] abs_sat(input logic [IQ_W-1:0] x);
      if (!x[IQ_W-1])                           return x;
      else if (x == {1'b1, {(IQ_W-1){1'b0}}})   return {1'b0, {(IQ_W-1){1'b1}}};
      else                                      return -x;
   endfunction

   localparam int unsigned        LOG_N    = $clog2(NFFT);
   localparam int unsigned        IDX_W    = LOG_N + 1;
   localparam logic [IDX_W-1:0]   NFFT_IDX = IDX_W'(NFFT);
   localparam logic [LOG_N-1:0]   LAST_IDX = LOG_N'(find_last(DATA_MASK));
   localparam logic [IQ_W-1:0]    THR      = IQ_W'(QAM16_THR);

   logic [7:0]        sym_q;
   logic [IDX_W-1:0]  idx_q, cur_idx, idx_d;
   logic [1:0]        mode_q, cur_mode;
   logic              sym_change, in_range, first_smp, is_data_sym, take, is_last;
   logic              short_sym, rsv_err, final_sym;

   // Input-stage register, then demap register, then packer.
   logic              a_vld, a_clr, a_arm, a_last;
   logic [IQ_W-1:0]   a_r, a_i;
   logic [1:0]        a_mode;
   logic              d_vld, d_clr, d_arm, d_last;
   logic [3:0]        d_bits;
   logic [2:0]        d_n;

   logic [7:0]        acc_q, base_acc, pk_acc;
   logic [3:0]        cnt_q, base_cnt, pk_cnt;
   logic              byte_done, armed_q, overflow_q, symerr_q, fifo_drop;
   axis_byte_t        wr_byte, rd_byte;

   assign sym_change  = (io_inputSymbol != sym_q);
   assign cur_idx     = sym_change ? '0 : idx_q;
   assign in_range    = (cur_idx < NFFT_IDX);
   assign first_smp   = io_inputDataEn && (cur_idx == '0);
   assign cur_mode    = first_smp ? io_modSel : mode_q;
   assign is_data_sym = (io_inputSymbol >= SYM_DATA0);
   assign take        = io_inputDataEn && is_data_sym && in_range &&
                        DATA_MASK[cur_idx[LOG_N-1:0]] && (cur_mode != MOD_RSV);
   assign idx_d       = cur_idx + {{(IDX_W-1){1'b0}}, io_inputDataEn && in_range};
   assign final_sym   = ({1'b0, io_inputSymbol} == 9'd2 + {1'b0, io_numSymbols});
   assign is_last     = final_sym && (cur_idx[LOG_N-1:0] == LAST_IDX);
   assign short_sym   = sym_change && (idx_q != '0) && (idx_q != NFFT_IDX);
   assign rsv_err     = first_smp && is_data_sym && (io_modSel == MOD_RSV);

   // Symbol changes restart the byte; samples per symbol divide evenly into bytes otherwise.
   always_comb begin
      base_acc = d_clr ? '0 : acc_q;
      base_cnt = d_clr ? '0 : cnt_q;
      pk_acc   = base_acc;
      pk_cnt   = base_cnt;
      if (d_vld) begin
         case (d_n)
            3'd1:    pk_acc = {base_acc[6:0], d_bits[3]};
            3'd2:    pk_acc = {base_acc[5:0], d_bits[3:2]};
            3'd4:    pk_acc = {base_acc[3:0], d_bits};
            default: pk_acc = base_acc;
         endcase
         pk_cnt = base_cnt + {1'b0, d_n};
      end
   end

   assign byte_done = d_vld && (pk_cnt == 4'd8);
   assign wr_byte   = '{data: pk_acc, last: d_last, user: armed_q};

   always_ff @(posedge CLK or negedge Rst_n) begin
      if (!Rst_n) begin
         sym_q      <= '0;
         idx_q      <= '0;
         mode_q     <= MOD_BPSK;
         a_vld      <= 1'b0;
         a_clr      <= 1'b0;
         a_arm      <= 1'b0;
         a_last     <= 1'b0;
         a_r        <= '0;
         a_i        <= '0;
         a_mode     <= MOD_BPSK;
         d_vld      <= 1'b0;
         d_clr      <= 1'b0;
         d_arm      <= 1'b0;
         d_last     <= 1'b0;
         d_bits     <= '0;
         d_n        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         armed_q    <= 1'b0;
         overflow_q <= 1'b0;
         symerr_q   <= 1'b0;
      end else begin
         sym_q <= io_inputSymbol;
         idx_q <= idx_d;
         if (first_smp) mode_q <= io_modSel;
         a_vld <= take;
         a_clr <= sym_change;
         a_arm <= io_inputDataEn && (io_inputSymbol == SYM_LONG1);
         if (take) begin
            a_r    <= io_inputDataR;
            a_i    <= io_inputDataI;
            a_mode <= cur_mode;
            a_last <= is_last;
         end
         d_vld  <= a_vld;
         d_clr  <= a_clr;
         d_arm  <= a_arm;
         d_last <= a_last;
         d_bits <= demap(a_mode, a_r[IQ_W-1], a_i[IQ_W-1],
                         abs_sat(a_r) < THR, abs_sat(a_i) < THR);
         d_n    <= bits_per_sym(a_mode);
         acc_q  <= pk_acc;
         cnt_q  <= byte_done ? '0 : pk_cnt;
         // Arm travels with the pipeline so late bytes of a previous frame stay untagged.
         if (d_arm)          armed_q <= 1'b1;
         else if (byte_done) armed_q <= 1'b0;
         if (fifo_drop)            overflow_q <= 1'b1;
         if (short_sym || rsv_err) symerr_q   <= 1'b1;
      end
   end

   axis_sync_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (Rst_n),
      .wr_en     (byte_done),
      .wr_data   (wr_byte),
      .wr_drop   (fifo_drop),
      .out_valid (io_axisOut_valid),
      .out_ready (io_axisOut_ready),
      .out_data  (rd_byte),
      .level     (io_fifoLevel)
   );

   assign io_axisOut_payload_data = rd_byte.data;
   assign io_axisOut_payload_last = rd_byte.last;
   assign io_axisOut_payload_user = rd_byte.user;
   assign io_overflow             = overflow_q;
   assign io_symErr               = symerr_q;

endmodule
